// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencing controller for an external combinational 8x8
// signed multiplier. It streams LEN operand pairs onto registered multiplier
// inputs, accumulates the sign-extended 16-bit products (wrapping modulo
// 2^ACC_W with a sticky signed-overflow flag) and returns one result per job
// over a valid/ready stream. The multiplier sits outside so exact or
// approximate variants can be swapped without touching this block.
module mac_seq_ctrl #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             p_vld_q, p_vld_d;
  logic [7:0]       mul_a_q, mul_a_d;
  logic [7:0]       mul_b_q, mul_b_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic             hs_s;
  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W-1:0] acc_sum_s;

  // Signed overflow of a two's-complement add: equal operand signs, different sum sign.
  function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                   input logic [ACC_W-1:0] b,
                                   input logic [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  assign hs_s       = in_valid & in_ready_q;
  assign prod_ext_s = ACC_W'($signed(mul_o));
  assign acc_sum_s  = acc_q + prod_ext_s;

  // Next-state logic: FSM sequencing, operand capture, accumulation and output staging.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    p_vld_d     = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    // The product registered last cycle is consumed now, whatever the state.
    if (p_vld_q) begin
      acc_d = acc_sum_s;
      ovf_d = ovf_q | add_ovf(acc_q, prod_ext_s, acc_sum_s);
    end else begin
      acc_d = acc_q;
      ovf_d = ovf_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          p_vld_d = 1'b0;
          if (len != {LEN_W{1'b0}}) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (hs_s) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          p_vld_d = 1'b1;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          p_vld_d = 1'b0;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Capture the final sum on entry to DONE so the result stays frozen while stalled.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      out_data_d = acc_d;
      out_ovf_d  = ovf_d;
    end else begin
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
    end

    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_RUN) && (rem_d != {LEN_W{1'b0}});
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      p_vld_q     <= 1'b0;
      mul_a_q     <= 8'd0;
      mul_b_q     <= 8'd0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      p_vld_q     <= p_vld_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: two instances (ACC_W=24 and ACC_W=16) share one
// input stream, each with its own exact multiplier. Results are checked
// against an integer dot-product model with wrap and overflow rules.
module tb_mac_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_ready;

  logic        busy24, in_ready24, out_valid24, out_ovf24;
  logic [7:0]  mul_a24, mul_b24;
  logic [15:0] mul_o24;
  logic [23:0] out_data24;

  logic        busy16, in_ready16, out_valid16, out_ovf16;
  logic [7:0]  mul_a16, mul_b16;
  logic [15:0] mul_o16;
  logic [15:0] out_data16;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  int qa[$];
  int qb[$];

  // Exact multipliers standing in for the external unit.
  assign mul_o24 = 16'($signed(mul_a24)) * 16'($signed(mul_b24));
  assign mul_o16 = 16'($signed(mul_a16)) * 16'($signed(mul_b16));

  mac_seq_ctrl #(.ACC_W(24), .LEN_W(8)) dut24 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy24),
    .in_valid(in_valid), .in_ready(in_ready24), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a24), .mul_b(mul_b24), .mul_o(mul_o24),
    .out_valid(out_valid24), .out_ready(out_ready),
    .out_data(out_data24), .out_ovf(out_ovf24)
  );

  mac_seq_ctrl #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_o(mul_o16),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_data(out_data16), .out_ovf(out_ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Dot product of qa/qb in plain integer arithmetic, wrapped to w bits.
  task automatic model(input int w, output logic [63:0] data, output logic ovf);
    longint s, s2, mn, mx, mask, m;
    s = 0;
    ovf = 1'b0;
    mask = (longint'(1) << w) - 1;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    foreach (qa[i]) begin
      s2 = s + longint'(qa[i]) * longint'(qb[i]);
      if (s2 > mx || s2 < mn) ovf = 1'b1;
      m = s2 & mask;
      if (m > mx) m = m - (longint'(1) << w);
      s = m;
    end
    data = 64'(s & mask);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from the current (idle) cycle through result acceptance.
  task automatic run_job(input int bubble, input int stall, input bit poke,
                         output int lat);
    int L, idx, t0, last_hs, budget;
    bit hs;
    logic [63:0] e24, e16;
    logic eo24, eo16;
    L = qa.size();
    idx = 0;
    last_hs = 0;
    model(24, e24, eo24);
    model(16, e16, eo16);
    out_ready = 1'b0;
    start = 1'b1;
    len = 8'(L);
    t0 = cyc;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy24), 64'd1);
    if (L > 0) chk("in_ready_after_start", 64'(in_ready24), 64'd1);
    budget = 0;
    while (out_valid24 !== 1'b1 && budget < 3000) begin
      if (in_ready24 === 1'b1 && idx < L && $urandom_range(0, 99) >= bubble) begin
        in_valid = 1'b1;
        in_a = 8'(qa[idx]);
        in_b = 8'(qb[idx]);
      end else begin
        in_valid = 1'b0;
      end
      hs = in_valid && in_ready24;
      step();
      budget++;
      if (hs) begin
        idx++;
        last_hs = cyc - 1;
        if (idx == L) chk("in_ready_drop", 64'(in_ready24), 64'd0);
      end
    end
    in_valid = 1'b0;
    chk("out_valid_seen", 64'(out_valid24), 64'd1);
    chk("pairs_consumed", 64'(idx), 64'(L));
    lat = cyc - t0;
    if (L > 0) chk("latency_after_last", 64'(cyc - last_hs), 64'd2);
    else chk("latency_len0", 64'(lat), 64'd1);
    chk("data24", 64'(out_data24), e24);
    chk("ovf24", 64'(out_ovf24), 64'(eo24));
    chk("data16", 64'(out_data16), e16);
    chk("ovf16", 64'(out_ovf16), 64'(eo16));
    for (int s = 0; s < stall; s++) begin
      if (poke && s == stall / 2) begin
        start = 1'b1;
        len = 8'd5;
      end else begin
        start = 1'b0;
      end
      step();
      chk("stall_hold", {out_valid24, out_ovf24, 40'(out_data24)}, {1'b1, eo24, e24[39:0]});
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_after_accept", {62'd0, busy24, out_valid24}, 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {busy24, in_ready24, out_valid24, out_ovf24, mul_a24, mul_b24, out_data24},
        64'd0);
    chk(tag, {busy16, in_ready16, out_valid16, out_ovf16, mul_a16, mul_b16, out_data16},
        64'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    start = 1'b0;
    len = 8'd0;
    in_valid = 1'b0;
    in_a = 8'd0;
    in_b = 8'd0;
    out_ready = 1'b0;
    #3;
    chk_reset_vals("reset_values");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Three pairs, no bubbles, exact latency.
    qa = '{1, -3, 127};
    qb = '{2, 4, 127};
    run_job(0, 0, 1'b0, lat);
    chk("t1_data", 64'(out_data24), 64'd16119);
    chk("t1_latency", 64'(lat), 64'd5);

    // 255 pairs of (-128,-128) with random gaps.
    qa.delete();
    qb.delete();
    for (int i = 0; i < 255; i++) begin
      qa.push_back(-128);
      qb.push_back(-128);
    end
    run_job(40, 0, 1'b0, lat);
    chk("t2_data", 64'(out_data24), 64'd4177920);

    // Overflow in the 16-bit instance, then a clean job clears it.
    qa = '{127, 127, 127};
    qb = '{127, 127, 127};
    run_job(0, 0, 1'b0, lat);
    chk("t3_data16", 64'(out_data16), 64'h0000_BD03);
    chk("t3_ovf16", 64'(out_ovf16), 64'd1);
    qa = '{2};
    qb = '{3};
    run_job(0, 0, 1'b0, lat);
    chk("t3b_data16", 64'(out_data16), 64'd6);
    chk("t3b_ovf16", 64'(out_ovf16), 64'd0);

    // Zero-length job with a 10-cycle output stall and a stray start.
    qa.delete();
    qb.delete();
    run_job(0, 10, 1'b1, lat);
    chk("t4_data", 64'(out_data24), 64'd0);

    // Reset in the middle of a 5-pair job.
    start = 1'b1;
    len = 8'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 8'(i + 1);
      in_b = 8'(i + 3);
      step();
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midjob_reset");
    step();
    rst_n = 1'b1;
    step();
    qa = '{5, 7};
    qb = '{-6, 8};
    run_job(0, 0, 1'b0, lat);
    chk("t5_data", 64'(out_data24), 64'd26);

    // Random jobs against the model.
    for (int j = 0; j < 1000; j++) begin
      int n;
      n = $urandom_range(1, 32);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(int'($urandom_range(0, 255)) - 128);
        qb.push_back(int'($urandom_range(0, 255)) - 128);
      end
      run_job(20, $urandom_range(0, 2), 1'b0, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller that drives one external 8x8 signed multiplier (exact or approximate variant, combinational, 16-bit product) to compute a dot product of LEN operand pairs for a CNN neuron/kernel window. It accepts operand pairs over a valid/ready stream, registers them onto the multiplier inputs, accumulates sign-extended products, and returns one result per job over a second valid/ready stream. Keeping the multiplier outside the block lets any multiplier variant be swapped in without touching the controller.

## Interface
- ACC_W, 24: accumulator and result width in bits; legal range 16..32.
- LEN_W, 8: width of the job length field.

- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs in the job (unsigned); sampled with start.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept a pair.
- in_a  in  8  signed operand A.
- in_b  in  8  signed operand B.
- mul_a  out  8  registered operand to multiplier input A.
- mul_b  out  8  registered operand to multiplier input B.
- mul_o  in  16  signed product from multiplier; combinational from mul_a/mul_b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  signed accumulated result, wrapped modulo 2^ACC_W.
- out_ovf  out  1  sticky signed-overflow flag for the job; valid with out_data.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0, out_valid=0. On start: latch remaining=len, clear acc, ovf and p_vld. If len!=0 go to RUN; if len==0 go to DONE (result 0, ovf 0).
- RUN: in_ready=1 while remaining>0. Handshake (in_valid&in_ready): mul_a<=in_a, mul_b<=in_b, p_vld<=1, remaining-=1. No handshake: p_vld<=0; mul_a/mul_b hold.
- Every cycle with p_vld=1: acc<=acc+sext(mul_o) to ACC_W. Set ovf if operand signs are equal and the sum sign differs. ovf stays set until next start.
- Handshake that takes remaining 1->0: go to DRAIN. in_ready is 0 from the next cycle.
- DRAIN: one cycle. The final product is accumulated. Go to DONE.
- DONE: out_valid=1, out_data=acc, out_ovf=ovf, all held stable until out_ready. On out_valid&out_ready go to IDLE.
- start outside IDLE is ignored. len is not re-sampled.
- The multiplier is treated as ideal combinational. Its output is consumed exactly one cycle after its operands are registered. The controller does not check product correctness, so approximate variants are permitted.

## Timing
- Reset values: state=IDLE, busy=0, in_ready=0, mul_a=0, mul_b=0, out_valid=0, out_data=0, out_ovf=0. Internal acc, remaining and p_vld are also 0.
- Reset asserted mid-job aborts immediately with no result. After release the block is in IDLE and the previous partial job is lost.
- start at cycle t: busy=1 and in_ready=1 from t+1.
- Pair accepted at cycle k: on mul_a/mul_b at k+1, added to acc at end of k+1.
- Throughput: 1 pair/cycle with continuous in_valid. A job of N pairs with no stalls takes start→out_valid = N+2 cycles.
- Last pair accepted at cycle L: DRAIN at L+1, out_valid at L+2.
- len==0: out_valid at t+1.
- out_ready high on the first DONE cycle: IDLE next cycle. The next start can be sampled in that IDLE cycle, so minimum job-to-job gap is 1 idle cycle.
- Input bubbles (in_valid low) only stretch RUN. Result is independent of bubble pattern.
- Output stall (out_ready low) holds DONE indefinitely with all outputs stable.

## Test plan
- ACC_W=24, len=3, pairs (1,2),(-3,4),(127,127), no bubbles: out_data=16119, out_ovf=0, out_valid exactly 5 cycles after start.
- len=255, all pairs (-128,-128), random in_valid gaps: out_data=4177920, out_ovf=0, in_ready drops right after 255th handshake.
- ACC_W=16, len=3, pairs (127,127)x3: out_data=-17149 (0xBD03), out_ovf=1. Next job len=1 (2,3): out_data=6, out_ovf=0.
- len=0 start: out_valid next cycle, out_data=0. Hold out_ready=0 for 10 cycles: outputs stable. Pulse start during the stall: ignored.
- Assert rst_n=0 after 2 of 5 pairs: all outputs at reset values. New job len=2, pairs (5,-6),(7,8): out_data=26.
- Equivalence: 1000 random jobs (len 1..32) checked against a golden model using the bench's multiplier instance (exact variant: matches the integer dot product).
